// File: rtl/shared_fn_scheduler.sv
// shared_fn_scheduler: round-robin front end that lets N_REQ requesters share
// one pipelined, fixed-latency function unit. Each requester holds at most one
// operation; a tag pipeline matched to the unit latency routes every result
// back to its issuer, and the result is held there until it is accepted.
module shared_fn_scheduler #(
   parameter int N_REQ   = 4,
   parameter int ARG_W   = 8,
   parameter int RES_W   = 16,
   parameter int LATENCY = 3
) (
   input  logic                     i_clk,
   input  logic                     i_rstn,
   input  logic [N_REQ-1:0]         i_req_valid,
   input  logic [N_REQ*ARG_W-1:0]   i_req_arg,
   output logic [N_REQ-1:0]         o_req_ready,
   output logic [N_REQ-1:0]         o_rsp_valid,
   output logic [N_REQ*RES_W-1:0]   o_rsp_data,
   input  logic [N_REQ-1:0]         i_rsp_ready,
   output logic                     o_fn_valid,
   output logic [ARG_W-1:0]         o_fn_arg,
   input  logic [RES_W-1:0]         i_fn_result,
   output logic                     o_busy
);

   localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [TAG_W-1:0]  ptr_reg;
   logic [LATENCY-1:0] trk_valid_reg;
   logic [TAG_W-1:0]  trk_tag_reg [LATENCY];

   logic [N_REQ-1:0]  eligible;
   logic [N_REQ-1:0]  busy_vec;
   logic [N_REQ-1:0]  grant;
   logic              grant_found;
   logic [TAG_W-1:0]  grant_idx;
   logic              fn_issue;
   logic              cap_valid;
   logic [TAG_W-1:0]  cap_tag;
   int                scan_idx;

   // Round-robin scan from ptr with wrap; first eligible requester wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = 0;
      grant       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = int'(ptr_reg) + k;
         if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
         if (!grant_found && eligible[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = TAG_W'(scan_idx);
         end
      end
      // Nothing is granted while reset is held, even though states read IDLE.
      for (int n = 0; n < N_REQ; n++) begin
         grant[n] = i_rstn && grant_found && (grant_idx == TAG_W'(n));
      end
   end

   assign fn_issue    = i_rstn && grant_found;
   assign o_req_ready = grant;
   assign o_fn_valid  = fn_issue;
   assign o_fn_arg    = fn_issue ? i_req_arg[grant_idx*ARG_W +: ARG_W] : '0;

   assign cap_valid = trk_valid_reg[LATENCY-1];
   assign cap_tag   = trk_tag_reg[LATENCY-1];
   assign o_busy    = |busy_vec;

   // Pointer moves to the slot after the requester just granted.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         ptr_reg <= '0;
      end else if (fn_issue) begin
         ptr_reg <= (grant_idx == TAG_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Tag pipeline mirrors the unit latency; the tail lines up with i_fn_result.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         trk_valid_reg <= '0;
         for (int i = 0; i < LATENCY; i++) trk_tag_reg[i] <= '0;
      end else begin
         trk_valid_reg[0] <= fn_issue;
         trk_tag_reg[0]   <= grant_idx;
         for (int i = 1; i < LATENCY; i++) begin
            trk_valid_reg[i] <= trk_valid_reg[i-1];
            trk_tag_reg[i]   <= trk_tag_reg[i-1];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         localparam logic [TAG_W-1:0] MY_TAG = TAG_W'(gi);
         logic [1:0]       state_reg;
         logic [RES_W-1:0] rsp_data_reg;

         assign eligible[gi]                  = i_req_valid[gi] && (state_reg == ST_IDLE);
         assign busy_vec[gi]                  = (state_reg != ST_IDLE);
         assign o_rsp_valid[gi]               = (state_reg == ST_DONE);
         assign o_rsp_data[gi*RES_W +: RES_W] = rsp_data_reg;

         // IDLE -> BUSY on grant, BUSY -> DONE on tagged capture, DONE -> IDLE on accept.
         always_ff @(posedge i_clk) begin
            if (!i_rstn) begin
               state_reg    <= ST_IDLE;
               rsp_data_reg <= '0;
            end else begin
               case (state_reg)
                  ST_IDLE: if (grant[gi]) state_reg <= ST_BUSY;
                  ST_BUSY: if (cap_valid && cap_tag == MY_TAG) begin
                     state_reg    <= ST_DONE;
                     rsp_data_reg <= i_fn_result;
                  end
                  ST_DONE: if (i_rsp_ready[gi]) state_reg <= ST_IDLE;
                  default: state_reg <= ST_IDLE;
               endcase
            end
         end
      end
   endgenerate

   // One operation per requester means live tracker entries never share a tag.
   always_ff @(posedge i_clk) begin
      if (i_rstn) begin
         for (int i = 0; i < LATENCY; i++) begin
            assert (!trk_valid_reg[i] || int'(trk_tag_reg[i]) < N_REQ);
            for (int j = i + 1; j < LATENCY; j++) begin
               assert (!(trk_valid_reg[i] && trk_valid_reg[j] &&
                         trk_tag_reg[i] == trk_tag_reg[j]));
            end
         end
      end
   end

endmodule

// File: tb/tb_shared_fn_scheduler.sv
// Directed bench for shared_fn_scheduler with a function-unit model (arg*3,
// three-cycle latency). Inputs change 1 time unit after the rising edge and
// outputs are sampled 2 units later, well clear of either clock edge.
module tb_shared_fn_scheduler;

   localparam int N_REQ   = 4;
   localparam int ARG_W   = 8;
   localparam int RES_W   = 16;
   localparam int LATENCY = 3;

   logic                   i_clk = 1'b0;
   logic                   i_rstn;
   logic [N_REQ-1:0]       i_req_valid;
   logic [N_REQ*ARG_W-1:0] i_req_arg;
   logic [N_REQ-1:0]       o_req_ready;
   logic [N_REQ-1:0]       o_rsp_valid;
   logic [N_REQ*RES_W-1:0] o_rsp_data;
   logic [N_REQ-1:0]       i_rsp_ready;
   logic                   o_fn_valid;
   logic [ARG_W-1:0]       o_fn_arg;
   logic [RES_W-1:0]       i_fn_result;
   logic                   o_busy;

   localparam logic [N_REQ*ARG_W-1:0] ARGS = {8'h23, 8'h22, 8'h21, 8'h20};

   int checks = 0;
   int errors = 0;

   shared_fn_scheduler #(
      .N_REQ(N_REQ), .ARG_W(ARG_W), .RES_W(RES_W), .LATENCY(LATENCY)
   ) dut (
      .i_clk(i_clk), .i_rstn(i_rstn),
      .i_req_valid(i_req_valid), .i_req_arg(i_req_arg), .o_req_ready(o_req_ready),
      .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .i_rsp_ready(i_rsp_ready),
      .o_fn_valid(o_fn_valid), .o_fn_arg(o_fn_arg), .i_fn_result(i_fn_result),
      .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   // Function unit model: not reset, so pre-reset issues still emerge late.
   logic [ARG_W-1:0] fn_pipe [LATENCY];
   initial for (int i = 0; i < LATENCY; i++) fn_pipe[i] = '0;
   always @(posedge i_clk) begin
      fn_pipe[0] <= o_fn_valid ? o_fn_arg : '0;
      for (int i = 1; i < LATENCY; i++) fn_pipe[i] <= fn_pipe[i-1];
   end
   assign i_fn_result = RES_W'(fn_pipe[LATENCY-1]) * 16'd3;

   // Expected tables for the wrap/skip and fairness scenarios.
   logic [3:0] wr_ready [8]  = '{4'h8, 4'h2, 4'h0, 4'h0, 4'h0, 4'h8, 4'h2, 4'h0};
   logic [3:0] wr_rsp   [8]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h2, 4'h0, 4'h0};
   logic [3:0] fa_ready [11] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1};
   logic [3:0] fa_rsp   [11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic reset_pulse();
      i_rstn = 1'b0;
      step();
      i_rstn = 1'b1;
   endtask

   function automatic logic [RES_W-1:0] rsp_of(input int n);
      return o_rsp_data[n*RES_W +: RES_W];
   endfunction

   function automatic int onehot_idx(input logic [3:0] v);
      int r = 0;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Checks grant, issue strobe/argument and response bits for one cycle.
   task automatic check_cycle(input string tag, input logic [3:0] er, input logic [3:0] ev);
      logic [ARG_W-1:0] exp_arg;
      exp_arg = (er == 4'h0) ? 8'h00 : ARGS[onehot_idx(er)*ARG_W +: ARG_W];
      check({tag, "_ready"}, o_req_ready, er);
      check({tag, "_fn_valid"}, o_fn_valid, er != 4'h0);
      check({tag, "_fn_arg"}, o_fn_arg, exp_arg);
      check({tag, "_rsp_valid"}, o_rsp_valid, ev);
      for (int n = 0; n < N_REQ; n++)
         if (ev[n]) check({tag, "_rsp_data"}, rsp_of(n), 16'(ARGS[n*ARG_W +: ARG_W]) * 16'd3);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt0, cnt1, cnt2, cnt3;

      // ---------------- reset state ----------------
      i_rstn = 1'b0; i_req_valid = '0; i_req_arg = ARGS; i_rsp_ready = 4'hF;
      step(); step();
      i_req_valid = 4'hF;
      #2;
      check("rst_ready", o_req_ready, 4'h0);
      check("rst_fn_valid", o_fn_valid, 1'b0);
      check("rst_fn_arg", o_fn_arg, 8'h00);
      check("rst_rsp_valid", o_rsp_valid, 4'h0);
      check("rst_rsp_data", o_rsp_data, 64'h0);
      check("rst_busy", o_busy, 1'b0);
      $display("reset state checked");
      step();
      i_rstn = 1'b1; i_req_valid = '0;

      // ---------------- single request ----------------
      i_req_valid = 4'b0100;
      i_req_arg   = {8'h23, 8'h11, 8'h21, 8'h20};
      #2;
      check("single_c0_ready", o_req_ready, 4'b0100);
      check("single_c0_fn_valid", o_fn_valid, 1'b1);
      check("single_c0_fn_arg", o_fn_arg, 8'h11);
      step();
      i_req_valid = '0;
      for (int c = 1; c <= 3; c++) begin
         #2;
         check("single_wait_rsp_valid", o_rsp_valid, 4'h0);
         check("single_wait_busy", o_busy, 1'b1);
         step();
      end
      #2;
      check("single_c4_rsp_valid", o_rsp_valid, 4'b0100);
      check("single_c4_rsp_data", rsp_of(2), 16'h0033);
      step();
      #2;
      check("single_c5_rsp_valid", o_rsp_valid, 4'h0);
      check("single_c5_busy", o_busy, 1'b0);
      $display("single request: requester 2 arg 0x11 -> 0x0033");
      step();

      // ---------------- wrap and skip (ptr = 3) ----------------
      i_req_arg = ARGS; i_req_valid = 4'b1010;
      for (int c = 0; c < 8; c++) begin
         #2;
         check_cycle("wrap", wr_ready[c], wr_rsp[c]);
         step();
      end
      i_req_valid = '0;
      for (int c = 0; c < 8; c++) step();
      #2;
      check("wrap_drain_busy", o_busy, 1'b0);
      $display("wrap/skip: grants 3,1,3 with requesters 0 and 2 idle");

      // ---------------- fairness ----------------
      reset_pulse();
      i_req_valid = 4'hF;
      for (int c = 0; c < 11; c++) begin
         #2;
         check_cycle("fair", fa_ready[c], fa_rsp[c]);
         step();
      end
      i_req_valid = '0;
      for (int c = 0; c < 8; c++) step();
      #2;
      check("fair_drain_busy", o_busy, 1'b0);
      $display("fairness: round-robin 0,1,2,3 then 0 at cycle 5");

      // ---------------- back-pressure on requester 1 ----------------
      reset_pulse();
      i_req_valid = 4'hF; i_rsp_ready = 4'b1101;
      cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0;
      for (int c = 0; c <= 16; c++) begin
         if (c == 15) i_rsp_ready = 4'hF;
         #2;
         if (c >= 2 && c <= 15) check("bp_no_grant1", o_req_ready[1], 1'b0);
         if (c >= 5 && c <= 15) begin
            check("bp_rsp_valid1", o_rsp_valid[1], 1'b1);
            check("bp_rsp_data1", rsp_of(1), 16'h0063);
         end
         if (c == 16) check("bp_released", o_rsp_valid[1], 1'b0);
         if (c >= 2 && c <= 14) begin
            if (o_req_ready[0]) cnt0++;
            if (o_req_ready[1]) cnt1++;
            if (o_req_ready[2]) cnt2++;
            if (o_req_ready[3]) cnt3++;
         end
         step();
      end
      check("bp_cnt0", cnt0, 2);
      check("bp_cnt1", cnt1, 0);
      check("bp_cnt2", cnt2, 3);
      check("bp_cnt3", cnt3, 3);
      i_req_valid = '0;
      for (int c = 0; c < 10; c++) step();
      #2;
      check("bp_drain_busy", o_busy, 1'b0);
      $display("back-pressure: requester 1 held %0d grants, others %0d/%0d/%0d", cnt1, cnt0, cnt2, cnt3);

      // ---------------- reset mid-flight ----------------
      reset_pulse();
      i_req_valid = 4'b0011;
      #2;
      check("mid_c0_ready", o_req_ready, 4'b0001);
      step();
      #2;
      check("mid_c1_ready", o_req_ready, 4'b0010);
      step();
      i_rstn = 1'b0; i_req_valid = 4'b0001;
      #2;
      check("mid_rst_ready", o_req_ready, 4'h0);
      check("mid_rst_fn_valid", o_fn_valid, 1'b0);
      check("mid_rst_fn_arg", o_fn_arg, 8'h00);
      step();
      i_rstn = 1'b1; i_req_valid = '0;
      for (int c = 3; c <= 6; c++) begin
         #2;
         check("mid_late_rsp_valid", o_rsp_valid, 4'h0);
         check("mid_late_rsp_data", o_rsp_data, 64'h0);
         check("mid_late_busy", o_busy, 1'b0);
         step();
      end
      i_req_valid = 4'b0001; i_req_arg = {8'h23, 8'h22, 8'h21, 8'h05};
      #2;
      check("mid_new_ready", o_req_ready, 4'b0001);
      check("mid_new_fn_arg", o_fn_arg, 8'h05);
      step();
      i_req_valid = '0;
      step(); step(); step();
      #2;
      check("mid_new_rsp_valid", o_rsp_valid, 4'b0001);
      check("mid_new_rsp_data", rsp_of(0), 16'h000F);
      step();
      #2;
      check("mid_new_busy", o_busy, 1'b0);
      $display("reset mid-flight: late results dropped, new request served");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
